// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, constants and bypass configuration for the register file.
// Build option: define REGFILE_BYPASS_EN to forward write data to same-cycle reads.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [DATA_W-1:0] ZERO_WORD     = '0;
    localparam logic              WRITE_ENABLE  = 1'b1;
    localparam logic              WRITE_DISABLE = 1'b0;
    localparam logic              READ_ENABLE   = 1'b1;
    localparam logic              READ_DISABLE  = 1'b0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational read port: zero forcing and optional write-through bypass.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic          rst_n,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] reg_data,
    output logic [DW-1:0] rdata
);

    logic bypass_hit;

    always_comb begin
        bypass_hit = BYPASS_EN && (we == WRITE_ENABLE) && (waddr == raddr);
        rdata      = '0;
        if (!rst_n || (re != READ_ENABLE) || (raddr == '0)) begin
            rdata = '0;
        end else if (bypass_hit) begin
            rdata = wdata;
        end else begin
            rdata = reg_data;
        end
    end

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - write-back register file: one write port, two combinational read ports.
// Build option: REGFILE_BYPASS_EN (see regfile_pkg) enables write-through on reads.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Entry 0 is never written, so it stays at its reset value and is pruned.
    always_comb begin
        regs_d = regs_q;
        if ((we == WRITE_ENABLE) && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_rd_port #(.DW(DATA_W), .AW(ADDR_W)) u_rd_port1 (
        .rst_n    (rst_n),
        .re       (re1),
        .raddr    (raddr1),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .reg_data (regs_q[raddr1]),
        .rdata    (rdata1)
    );

    regfile_rd_port #(.DW(DATA_W), .AW(ADDR_W)) u_rd_port2 (
        .rst_n    (rst_n),
        .re       (re2),
        .raddr    (raddr2),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .reg_data (regs_q[raddr2]),
        .rdata    (rdata2)
    );

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - directed and randomized checks of regfile against an array reference model.
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    logic [31:0] model [32];
    int          n_cmp;
    int          n_bad;

    regfile dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
            $error("%s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expect_rd(input logic re, input logic [4:0] ra);
        if (!rst_n || !re || ra == 5'd0) return 32'h0;
        if (BYP && we && waddr == ra) return wdata;
        return model[ra];
    endfunction

    task automatic check_ports(input string tag);
        check({tag, "_p1"}, rdata1, expect_rd(re1, raddr1));
        check({tag, "_p2"}, rdata2, expect_rd(re2, raddr2));
    endtask

    // Apply the pending write to the model, then advance one clock.
    task automatic tick();
        if (rst_n && we && waddr != 5'd0) model[waddr] = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2);
        we = w; waddr = wa; wdata = wd;
        re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
        #2;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd17);
        check("in_reset_p1", rdata1, 32'h0);
        check("in_reset_p2", rdata2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
            check("reset_val_p1", rdata1, 32'h0);
            check("reset_val_p2", rdata2, 32'h0);
        end

        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
        check("r5_p1", rdata1, 32'hDEADBEEF);
        check("r5_p2", rdata2, 32'hDEADBEEF);

        drive(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 1'b1, 5'd0);
        check("r0_same_cycle", rdata1, 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
        check("r0_after_p1", rdata1, 32'h0);
        check("r0_after_p2", rdata2, 32'h0);

        drive(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b1, 5'd7, 32'h2, 1'b1, 5'd7, 1'b1, 5'd7);
        check("r7_hazard_p1", rdata1, BYP ? 32'h2 : 32'h1);
        check("r7_hazard_p2", rdata2, BYP ? 32'h2 : 32'h1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
        check("r7_next_p1", rdata1, 32'h2);

        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b1, 5'd5);
        check("re1_off", rdata1, 32'h0);
        check("re2_on", rdata2, 32'hDEADBEEF);

        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom_range(0, 3) != 0), 5'($urandom),
                  1'($urandom_range(0, 3) != 0), 5'($urandom));
            check_ports("rand");
            tick();
        end

        drive(1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9);
        check("r9_written", rdata1, 32'hA5A5A5A5);
        drive(1'b1, 5'd9, 32'h0F0F0F0F, 1'b1, 5'd9, 1'b1, 5'd9);
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #1;
        check("rst_mid_p1", rdata1, 32'h0);
        check("rst_mid_p2", rdata2, 32'h0);
        @(posedge clk);
        #1;
        we = 1'b0;
        rst_n = 1'b1;
        #2;
        check("r9_after_rst_p1", rdata1, 32'h0);
        check("r9_after_rst_p2", rdata2, 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd5);
        check_ports("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
